// File: rtl/tff_ctrl_pkg.sv
// Shared op-codes and controller state encodings for the T flip-flop bank controller.
package tff_ctrl_pkg;

    localparam int unsigned OP_W = 2;

    localparam logic [OP_W-1:0] OP_LOAD  = 2'b00;
    localparam logic [OP_W-1:0] OP_UP    = 2'b01;
    localparam logic [OP_W-1:0] OP_DOWN  = 2'b10;
    localparam logic [OP_W-1:0] OP_CLEAR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_APPLY  = 3'd1,
        S_VERIFY = 3'd2,
        S_COUNT  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    // True for the two stepping ops.
    function automatic logic is_count_op(input logic [OP_W-1:0] op);
        return (op == OP_UP) || (op == OP_DOWN);
    endfunction

endpackage

// File: rtl/tff_step_mask.sv
// Toggle mask that steps a T flip-flop bank by +1 (dir=0) or -1 (dir=1).
module tff_step_mask #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] q,
    input  logic         dir,
    output logic [N-1:0] mask
);

    logic [N-1:0] w_bits;
    logic [N-1:0] w_mask;

    // Up counting propagates through ones, down counting through zeros.
    assign w_bits = dir ? ~q : q;

    // Bit i toggles when every lower bit propagates; bits at or above i are forced to 1.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < int'(N); i++) begin
            w_mask[i] = &(w_bits | ~N'((1 << i) - 1));
        end
    end

    assign mask = w_mask;

endmodule

// File: rtl/tff_bank_ctrl.sv
// Command sequencer driving the toggle vector of a T flip-flop bank: load, clear, count up/down.
module tff_bank_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [N-1:0]     cmd_data,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic [N-1:0]     q_in,
    output logic [N-1:0]     t_out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_op;
    logic [N-1:0]     r_target;
    logic [CNT_W-1:0] r_remain;
    logic             r_mismatch;

    logic             w_accept;
    logic [N-1:0]     w_mask;
    logic [N-1:0]     w_t_out;

    assign w_accept = cmd_valid && (r_state == S_IDLE);

    tff_step_mask #(
        .N (N)
    ) u_step_mask (
        .q    (q_in),
        .dir  (r_op == OP_DOWN),
        .mask (w_mask)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latched command, remaining step count and load verify flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op       <= OP_LOAD;
            r_target   <= '0;
            r_remain   <= '0;
            r_mismatch <= 1'b0;
        end else if (w_accept) begin
            r_op       <= cmd_op;
            r_target   <= (cmd_op == OP_LOAD) ? cmd_data : '0;
            r_remain   <= cmd_len;
            r_mismatch <= 1'b0;
        end else if (r_state == S_VERIFY) begin
            r_mismatch <= (q_in != r_target);
        end else if (r_state == S_COUNT) begin
            r_remain <= r_remain - CNT_W'(1);
        end
    end

    // Next-state and toggle vector; reset overrides the toggle so the bank clears cleanly.
    always_comb begin
        w_state_nxt = r_state;
        w_t_out     = '0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (!is_count_op(cmd_op)) begin
                        w_state_nxt = S_APPLY;
                    end else if (cmd_len == '0) begin
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_state_nxt = S_COUNT;
                    end
                end
            end
            S_APPLY: begin
                w_t_out     = q_in ^ r_target;
                w_state_nxt = S_VERIFY;
            end
            S_VERIFY: begin
                w_state_nxt = S_FINISH;
            end
            S_COUNT: begin
                w_t_out = w_mask;
                if (r_remain == CNT_W'(1)) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (rst) begin
            w_t_out = '0;
        end
    end

    assign t_out     = w_t_out;
    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_FINISH);
    assign err       = (r_state == S_FINISH) && r_mismatch && !is_count_op(r_op);

endmodule

// File: tb/tb_tff_bank_ctrl.sv
// Bench for tff_bank_ctrl with a behavioural T flip-flop bank alongside it.
module tb_tff_bank_ctrl;

    localparam int unsigned N     = 4;
    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [N-1:0]     cmd_data;
    logic [CNT_W-1:0] cmd_len;
    logic [N-1:0]     q_in;
    logic [N-1:0]     t_out;
    logic             busy;
    logic             done;
    logic             err;

    logic [N-1:0]     bank_q;
    logic             stuck;

    int n_checks;
    int n_fail;

    tff_bank_ctrl #(
        .N     (N),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_len   (cmd_len),
        .q_in      (q_in),
        .t_out     (t_out),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Toggle bank: q_next = q ^ t, synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) bank_q <= '0;
        else     bank_q <= bank_q ^ t_out;
    end

    // Optional read-back fault: bit 2 reads as 0.
    assign q_in = stuck ? (bank_q & 4'hB) : bank_q;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [N-1:0] data, input logic [CNT_W-1:0] len);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        n_checks++; if (t_out !== 4'h0) begin n_fail++; $display("FAIL reset_t: got %h expected 0", t_out); end
        n_checks++; if (q_in !== 4'h0) begin n_fail++; $display("FAIL reset_q: got %h expected 0", q_in); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load();
        send_cmd(2'b00, 4'hA, 8'd0);
        n_checks++; if (t_out !== 4'hA) begin n_fail++; $display("FAIL load_apply_t: got %h expected a", t_out); end
        n_checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL load_apply_busy: got busy=%b ready=%b expected 1/0", busy, cmd_ready); end
        tick();
        n_checks++; if (q_in !== 4'hA) begin n_fail++; $display("FAIL load_verify_q: got %h expected a", q_in); end
        n_checks++; if (t_out !== 4'h0 || done !== 1'b0) begin n_fail++; $display("FAIL load_verify_t: got t=%h done=%b expected 0/0", t_out, done); end
        tick();
        n_checks++; if (done !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL load_done: got done=%b err=%b expected 1/0", done, err); end
        tick();
        n_checks++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL load_after: got ready=%b done=%b expected 1/0", cmd_ready, done); end
    endtask

    task automatic test_count_up();
        logic [N-1:0] exp_t [3];
        logic [N-1:0] exp_q [3];
        exp_t = '{4'h1, 4'hF, 4'h1};
        exp_q = '{4'hE, 4'hF, 4'h0};
        send_cmd(2'b00, 4'hE, 8'd0);
        tick(); tick(); tick();
        n_checks++; if (q_in !== 4'hE) begin n_fail++; $display("FAIL up_preload: got %h expected e", q_in); end
        send_cmd(2'b01, 4'h0, 8'd3);
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (t_out !== exp_t[k] || q_in !== exp_q[k] || busy !== 1'b1) begin
                n_fail++; $display("FAIL up_step%0d: got t=%h q=%h busy=%b expected t=%h q=%h busy=1", k, t_out, q_in, busy, exp_t[k], exp_q[k]);
            end
            tick();
        end
        n_checks++; if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b1 || q_in !== 4'h1 || t_out !== 4'h0) begin
            n_fail++; $display("FAIL up_finish: got done=%b err=%b busy=%b q=%h t=%h expected 1/0/1/1/0", done, err, busy, q_in, t_out);
        end
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL up_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_count_down();
        logic [N-1:0] exp_t [2];
        logic [N-1:0] exp_q [2];
        exp_t = '{4'h1, 4'hF};
        exp_q = '{4'h1, 4'h0};
        send_cmd(2'b00, 4'h1, 8'd0);
        tick(); tick(); tick();
        send_cmd(2'b10, 4'h0, 8'd2);
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (t_out !== exp_t[k] || q_in !== exp_q[k]) begin
                n_fail++; $display("FAIL down_step%0d: got t=%h q=%h expected t=%h q=%h", k, t_out, q_in, exp_t[k], exp_q[k]);
            end
            tick();
        end
        n_checks++; if (done !== 1'b1 || err !== 1'b0 || q_in !== 4'hF) begin
            n_fail++; $display("FAIL down_finish: got done=%b err=%b q=%h expected 1/0/f", done, err, q_in);
        end
        tick();
    endtask

    task automatic test_verify_err();
        stuck = 1'b1;
        // Bank holds f, reads back as b; APPLY toggles b^4 = f, leaving the bank at 0.
        send_cmd(2'b00, 4'h4, 8'd0);
        n_checks++; if (t_out !== 4'hF) begin n_fail++; $display("FAIL stuck_apply_t: got %h expected f", t_out); end
        tick();
        tick();
        n_checks++; if (done !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL stuck_err: got done=%b err=%b expected 1/1", done, err); end
        tick();
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL stuck_err_idle: got %b expected 0", err); end
        send_cmd(2'b00, 4'h0, 8'd0);
        tick();
        tick();
        n_checks++; if (done !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL stuck_clean: got done=%b err=%b expected 1/0", done, err); end
        tick();
        stuck = 1'b0;
        n_checks++; if (q_in !== 4'h0) begin n_fail++; $display("FAIL stuck_q: got %h expected 0", q_in); end
    endtask

    task automatic test_len_zero();
        send_cmd(2'b00, 4'h5, 8'd0);
        tick(); tick(); tick();
        send_cmd(2'b01, 4'h0, 8'd0);
        n_checks++; if (done !== 1'b1 || err !== 1'b0 || t_out !== 4'h0 || q_in !== 4'h5) begin
            n_fail++; $display("FAIL len0_finish: got done=%b err=%b t=%h q=%h expected 1/0/0/5", done, err, t_out, q_in);
        end
        tick();
        n_checks++; if (done !== 1'b0 || cmd_ready !== 1'b1 || q_in !== 4'h5) begin
            n_fail++; $display("FAIL len0_idle: got done=%b ready=%b q=%h expected 0/1/5", done, cmd_ready, q_in);
        end
    endtask

    task automatic test_busy_hold();
        logic exp_done [4];
        exp_done = '{1'b0, 1'b0, 1'b1, 1'b0};
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_data  = 4'h3;
        cmd_len   = 8'd0;
        tick();
        cmd_data = 4'h9;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (done !== exp_done[k]) begin n_fail++; $display("FAIL hold_done%0d: got %b expected %b", k, done, exp_done[k]); end
            if (k == 2) cmd_valid = 1'b0;
            tick();
        end
        n_checks++; if (q_in !== 4'h3 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL hold_single: got q=%h busy=%b ready=%b expected 3/0/1", q_in, busy, cmd_ready);
        end
    endtask

    task automatic test_reset_mid();
        int n_done;
        n_done = 0;
        send_cmd(2'b01, 4'h0, 8'd10);
        tick(); tick(); tick();
        n_checks++; if (t_out !== 4'h1 || q_in !== 4'h6) begin n_fail++; $display("FAIL rstmid_pre: got t=%h q=%h expected 1/6", t_out, q_in); end
        rst = 1'b1;
        #1;
        n_checks++; if (t_out !== 4'h0) begin n_fail++; $display("FAIL rstmid_t: got %h expected 0", t_out); end
        tick();
        rst = 1'b0;
        n_checks++; if (q_in !== 4'h0 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_after: got q=%h busy=%b ready=%b done=%b expected 0/0/1/0", q_in, busy, cmd_ready, done);
        end
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done === 1'b1 || t_out !== 4'h0) n_done++;
        end
        n_checks++; if (n_done != 0) begin n_fail++; $display("FAIL rstmid_quiet: got %0d active cycles expected 0", n_done); end
    endtask

    task automatic test_random_back_to_back();
        logic [N-1:0] mq;
        logic [N-1:0] tgt;
        logic [N-1:0] et;
        logic [1:0]   op;
        int           len;
        int           done_k;
        mq = q_in;
        for (int it = 0; it < 40; it++) begin
            op  = 2'($urandom_range(0, 3));
            tgt = (op == 2'b11) ? 4'h0 : 4'($urandom_range(0, 15));
            len = int'($urandom_range(0, 12));
            if (op == 2'b00 || op == 2'b11) done_k = 3;
            else if (len == 0)              done_k = 1;
            else                            done_k = len + 1;
            n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_ready: got %b expected 1", it, cmd_ready); end
            send_cmd(op, tgt, 8'(len));
            for (int k = 1; k <= done_k; k++) begin
                et = 4'h0;
                if (k < done_k) begin
                    if (op == 2'b01)      et = mq ^ 4'(mq + 4'h1);
                    else if (op == 2'b10) et = mq ^ 4'(mq - 4'h1);
                    else if (k == 1)      et = mq ^ tgt;
                end
                n_checks++; if (t_out !== et || q_in !== mq || busy !== 1'b1 || done !== (k == done_k)) begin
                    n_fail++; $display("FAIL rnd%0d_cyc%0d op=%0d len=%0d: got t=%h q=%h busy=%b done=%b expected t=%h q=%h busy=1 done=%b",
                                       it, k, op, len, t_out, q_in, busy, done, et, mq, (k == done_k));
                end
                if (k == done_k) begin
                    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_err: got %b expected 0", it, err); end
                end
                if (k < done_k) begin
                    if (op == 2'b01)      mq = 4'(mq + 4'h1);
                    else if (op == 2'b10) mq = 4'(mq - 4'h1);
                    else if (k == 1)      mq = tgt;
                end
                tick();
            end
        end
        n_checks++; if (q_in !== mq) begin n_fail++; $display("FAIL rnd_final_q: got %h expected %h", q_in, mq); end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        stuck     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = '0;
        cmd_len   = '0;
        test_reset();
        test_load();
        test_count_up();
        test_count_down();
        test_verify_err();
        test_len_zero();
        test_busy_hold();
        test_reset_mid();
        test_random_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tff_bank_ctrl.md
Name: tff_bank_ctrl

Overview:
Sequencing controller for the parameterised T flip-flop bank (q_next = q ^ t, synchronous clear on rst). It accepts one command at a time over a valid/ready port and drives the bank's toggle vector to either load an absolute value, clear it, or step it as an up/down counter for a programmed number of cycles. It reads bank state back through q_in and, for loads, verifies the result. It sits between command/CSR logic and the toggle bank and is the bank's only toggle source.

Parameters:
N, 4, bank width (bits of t/q)
CNT_W, 8, width of step-count field

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset; shared with the toggle bank
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept; high only in IDLE
cmd_op  input  2  00 LOAD, 01 COUNT_UP, 10 COUNT_DOWN, 11 CLEAR
cmd_data  input  N  LOAD target; ignored for other ops
cmd_len  input  CNT_W  step count for COUNT_*; ignored otherwise
q_in  input  N  bank q outputs
t_out  output  N  toggle vector to bank
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle completion pulse
err  output  1  LOAD/CLEAR verify mismatch; valid only when done=1, else 0

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). Reset state: IDLE, cmd_ready=1, busy=0, done=0, err=0, t_out=0, counters/target regs 0.
- t_out combinational from registered state and q_in; forced 0 whenever rst=1, and 0 in IDLE, VERIFY, FINISH.
- Accept: cmd_valid & cmd_ready at rising edge latches op/data/len; cmd_valid while busy is ignored (not accepted).
- States: IDLE, APPLY, VERIFY, COUNT, FINISH.
- LOAD: IDLE -> APPLY (t_out = q_in ^ target, one cycle) -> VERIFY (t_out=0; mismatch flag = (q_in != target) registered) -> FINISH -> IDLE. Accept-to-done = 3 cycles.
- CLEAR: identical to LOAD with target 0.
- COUNT_UP/DOWN, len L > 0: IDLE -> COUNT for exactly L cycles -> FINISH -> IDLE.
  - up mask: t[0]=1, t[i]=&q_in[i-1:0].
  - down mask: t[0]=1, t[i]=&(~q_in[i-1:0]).
  - Remaining counter loaded with L, decremented each COUNT cycle; leave COUNT when it reaches 1 at the edge.
  - Final q = start +/- L mod 2^N; wrap is natural (F+1 -> 0, 0-1 -> F).
- COUNT with L=0: IDLE -> FINISH directly; t_out never nonzero; q unchanged.
- FINISH: done=1 for exactly that cycle. err = registered mismatch for LOAD/CLEAR; err=0 for COUNT ops. cmd_ready=0 in FINISH, so the next command is accepted no earlier than the cycle after done.
- Reset mid-operation: same edge returns to IDLE, bank clears to 0, no done pulse. Latched command is discarded.
- No back-pressure on completion; done is not held.

Decomposition:
- Shared package tff_ctrl_pkg:
  - op-code constants OP_LOAD/OP_UP/OP_DOWN/OP_CLEAR
  - state encodings S_IDLE..S_FINISH
- Sub-module tff_step_mask: parameter N, inputs q and dir, output N-bit up/down toggle mask (pure combinational prefix-AND).
- The FSM, length counter and verify register stay in tff_bank_ctrl.

Test Plan:
(N=4, bank instantiated alongside controller, same clk/rst)
1. Reset 2 cycles, then LOAD 0xA from q=0 -> APPLY cycle t_out=0xA; next cycle q=0xA, t_out=0; done=1/err=0 three cycles after accept; cmd_ready high the following cycle.
2. LOAD 0xE, then COUNT_UP len 3 -> t_out sequence 0x1, 0xF, 0x1; q sequence 0xF, 0x0, 0x1 (wrap); done with err=0, busy for 4 cycles.
3. LOAD 0x1, then COUNT_DOWN len 2 -> t_out 0x1 then 0xF; q 0x0 then 0xF; done err=0.
4. Bench forces q_in bit 2 stuck at 0, LOAD 0x4 -> VERIFY sees mismatch; done=1 with err=1; next LOAD 0x0 gives err=0.
5. COUNT_UP len 0 from q=0x5 -> done on the cycle after accept, t_out always 0, q stays 0x5. Also hold cmd_valid high during a busy LOAD -> only one command accepted.
6. rst asserted for one cycle mid COUNT_UP len 10 -> t_out 0 while rst high; next cycle q=0, busy=0, cmd_ready=1, no done pulse.
